video_dma_line_fetch: RTL and testbench

- UFI bus read DMA master. Streams RGB565 pixels from the external-RAM frame buffer into the video line FIFO on the system clock domain.
- Sits directly upstream of the SCLK→VCLK async FIFO in the video Tx path, as an alternative pixel source to the internal pixel generator.
- Configured by the video Tx CSR DMA fields (enable, cycle enable, start/end/add address); reports completion back to the CSR.
- Issues fixed-length read bursts and throttles on the FIFO's remaining-space alert.

---
 rtl/video_dma_line_fetch.sv | 133 +++++++++++++
 tb/tb_video_dma_line_fetch.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dma_line_fetch.sv
// UFI read DMA master: fetches fixed-length RGB565 bursts from the frame buffer into the video line FIFO.
// Optional VIDEO_DMA_BYTE_SWAP_EN swaps the bytes of each pixel for little-endian frame buffers.
module video_dma_line_fetch #(
  parameter int         pUfiDqBusWidth   = 16,
  parameter int         pUfiAdrsBusWidth = 32,
  parameter logic [3:0] pUfiAdrsMap      = 4'h2,
  parameter int         pDmaAdrsWidth    = 18,
  parameter int         pDmaBurstLength  = 256,
  parameter int         pColorDepth      = 16
) (
  input  logic                        iSCLK,
  input  logic                        iSRST,
  input  logic                        iDmaEnable,
  input  logic                        iDmaCycleEnable,
  input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsStart,
  input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsEnd,
  input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsAdd,
  output logic                        oDmaDone,
  output logic                        oFrameDone,
  output logic [pUfiAdrsBusWidth-1:0] oMUfiAdrs,
  output logic                        oMUfiRe,
  input  logic                        iMUfiRdy,
  input  logic [pUfiDqBusWidth-1:0]   iMUfiRd,
  input  logic                        iMUfiRvd,
  output logic [pColorDepth-1:0]      oWd,
  output logic                        oWe,
  input  logic                        iRemaingCntAlert,
  input  logic                        iFull,
  output logic                        oOverflow
);

  localparam int CntWidth = $clog2(pDmaBurstLength);
  localparam int PadWidth = pUfiAdrsBusWidth - 4 - pDmaAdrsWidth;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, NEXT, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [pDmaAdrsWidth-1:0] pointer;
  logic [pDmaAdrsWidth-1:0] start_l;
  logic [pDmaAdrsWidth-1:0] end_l;
  logic [pDmaAdrsWidth-1:0] add_l;
  logic                     cycle_l;
  logic [CntWidth-1:0]      word_cnt;
  logic [pDmaAdrsWidth:0]   sum;
  logic                     frame_end;
  logic                     fire;
  logic                     burst_last;
  logic                     accept;
  logic [pColorDepth-1:0]   pixel;

  // The extra sum bit catches wrap past the top of the DMA address space.
  assign sum        = {1'b0, pointer} + {1'b0, add_l};
  assign frame_end  = sum[pDmaAdrsWidth] || (sum[pDmaAdrsWidth-1:0] > end_l);
  assign fire       = (state == REQ) && iDmaEnable && iMUfiRdy && !iRemaingCntAlert;
  assign accept     = (state == WAIT) && iMUfiRvd;
  assign burst_last = accept && (&word_cnt);

`ifdef VIDEO_DMA_BYTE_SWAP_EN
  assign pixel = {iMUfiRd[7:0], iMUfiRd[15:8]};
`else
  assign pixel = iMUfiRd;
`endif

  always_ff @(posedge iSCLK) begin
    if (iSRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (iDmaEnable) state_next = REQ;
      REQ: begin
        if (!iDmaEnable) state_next = IDLE;
        else if (fire)   state_next = WAIT;
      end
      WAIT: if (burst_last) state_next = NEXT;
      NEXT: begin
        if (!iDmaEnable)  state_next = IDLE;
        else if (frame_end && !cycle_l) state_next = DONE;
        else              state_next = REQ;
      end
      DONE: if (!iDmaEnable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oMUfiRe    = fire;
    oMUfiAdrs  = '0;
    oFrameDone = (state == NEXT) && iDmaEnable && frame_end;
    oDmaDone   = (state == DONE);
    if (fire) oMUfiAdrs = {pUfiAdrsMap, {PadWidth{1'b0}}, pointer};
  end

  // The word counter wraps to zero on its own because the burst length is a power of two.
  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      pointer   <= '0;
      start_l   <= '0;
      end_l     <= '0;
      add_l     <= '0;
      cycle_l   <= 1'b0;
      word_cnt  <= '0;
      oWd       <= '0;
      oWe       <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oWe       <= accept;
      oOverflow <= oOverflow | (oWe & iFull);
      if (accept) begin
        oWd      <= pixel;
        word_cnt <= word_cnt + 1'b1;
      end
      if (state == IDLE && iDmaEnable) begin
        start_l <= iDmaAdrsStart;
        end_l   <= iDmaAdrsEnd;
        add_l   <= iDmaAdrsAdd;
        cycle_l <= iDmaCycleEnable;
        pointer <= iDmaAdrsStart;
      end
      if (state == NEXT && iDmaEnable) begin
        if (frame_end) begin
          if (cycle_l) pointer <= start_l;
        end else begin
          pointer <= sum[pDmaAdrsWidth-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_video_dma_line_fetch.sv
// Randomised self-checking bench for video_dma_line_fetch with a UFI slave responder and a burst-level address model.
module tb_video_dma_line_fetch;

  localparam int AW = 18;
  localparam int BL = 256;

  logic        iSCLK = 1'b0;
  logic        iSRST;
  logic        iDmaEnable;
  logic        iDmaCycleEnable;
  logic [AW-1:0] iDmaAdrsStart;
  logic [AW-1:0] iDmaAdrsEnd;
  logic [AW-1:0] iDmaAdrsAdd;
  logic        oDmaDone;
  logic        oFrameDone;
  logic [31:0] oMUfiAdrs;
  logic        oMUfiRe;
  logic        iMUfiRdy;
  logic [15:0] iMUfiRd;
  logic        iMUfiRvd;
  logic [15:0] oWd;
  logic        oWe;
  logic        iRemaingCntAlert;
  logic        iFull;
  logic        oOverflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_q[$];
  logic [15:0] we_q[$];
  logic [15:0] exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  int          frame_cnt = 0;
  int          exp_frames = 0;
  int          pending = 0;
  bit          slave_en = 1'b1;
  bit          gaps = 1'b0;
  bit          done_seen = 1'b0;
  bit          fixed_first = 1'b0;
  logic [15:0] slave_d;

  video_dma_line_fetch dut (
    .iSCLK(iSCLK), .iSRST(iSRST),
    .iDmaEnable(iDmaEnable), .iDmaCycleEnable(iDmaCycleEnable),
    .iDmaAdrsStart(iDmaAdrsStart), .iDmaAdrsEnd(iDmaAdrsEnd), .iDmaAdrsAdd(iDmaAdrsAdd),
    .oDmaDone(oDmaDone), .oFrameDone(oFrameDone),
    .oMUfiAdrs(oMUfiAdrs), .oMUfiRe(oMUfiRe), .iMUfiRdy(iMUfiRdy),
    .iMUfiRd(iMUfiRd), .iMUfiRvd(iMUfiRvd),
    .oWd(oWd), .oWe(oWe),
    .iRemaingCntAlert(iRemaingCntAlert), .iFull(iFull), .oOverflow(oOverflow)
  );

  always #5 iSCLK = ~iSCLK;

  // Pixel as it should appear at the FIFO for a given bus word.
  function automatic logic [15:0] pix(input logic [15:0] d);
`ifdef VIDEO_DMA_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  // Slave drives on the falling edge; outputs are sampled 2 time units before the rising edge.
  initial begin
    iMUfiRvd = 1'b0;
    iMUfiRd  = '0;
    forever begin
      @(posedge iSCLK);
      #5;
      if (slave_en) begin
        if (pending > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          slave_d = fixed_first ? 16'h1234 : 16'($urandom);
          fixed_first = 1'b0;
          iMUfiRvd = 1'b1;
          iMUfiRd  = slave_d;
          exp_data_q.push_back(pix(slave_d));
          pending--;
        end else begin
          iMUfiRvd = 1'b0;
          iMUfiRd  = 16'($urandom);
        end
      end
      #3;
      if (oMUfiRe === 1'b1) begin
        addr_q.push_back(oMUfiAdrs);
        pending += BL;
      end
      if (oWe === 1'b1) we_q.push_back(oWd);
      if (oFrameDone === 1'b1) frame_cnt++;
      if (oDmaDone === 1'b1) done_seen = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  // Burst-level reference: list of burst addresses and frame-end count, from plain arithmetic.
  task automatic model_run(input int unsigned s, input int unsigned e, input int unsigned a,
                           input bit cyc, input int maxb);
    longint p;
    p = s;
    exp_addr_q.delete();
    exp_frames = 0;
    forever begin
      exp_addr_q.push_back(32'h2000_0000 | 32'(p));
      if (exp_addr_q.size() >= maxb) break;
      if (p + a > e) begin
        exp_frames++;
        if (!cyc) break;
        p = s;
      end else begin
        p = p + a;
      end
    end
  endtask

  task automatic clear_model();
    addr_q.delete();
    we_q.delete();
    exp_data_q.delete();
    frame_cnt = 0;
    done_seen = 1'b0;
    pending   = 0;
  endtask

  task automatic start_run(input int unsigned s, input int unsigned e, input int unsigned a, input bit cyc);
    @(negedge iSCLK);
    iDmaAdrsStart   = AW'(s);
    iDmaAdrsEnd     = AW'(e);
    iDmaAdrsAdd     = AW'(a);
    iDmaCycleEnable = cyc;
    iDmaEnable      = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iSCLK);
      if (done_seen) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iSCLK);
      if (pending == 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge iSCLK);
  endtask

  task automatic test_reset();
    @(negedge iSCLK);
    iSRST = 1'b1; iDmaEnable = 1'b0; iDmaCycleEnable = 1'b0;
    iDmaAdrsStart = '0; iDmaAdrsEnd = '0; iDmaAdrsAdd = '0;
    iMUfiRdy = 1'b1; iRemaingCntAlert = 1'b0; iFull = 1'b0;
    repeat (3) @(negedge iSCLK);
    iSRST = 1'b0;
    @(negedge iSCLK);
    #4;
    checks++;
    if ({oMUfiRe, oWe, oFrameDone, oDmaDone, oOverflow} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b want 00000", {oMUfiRe, oWe, oFrameDone, oDmaDone, oOverflow});
    end
    checks++;
    if (oMUfiAdrs !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_adrs got %h want 00000000", oMUfiAdrs);
    end
    checks++;
    if (oWd !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_wd got %h want 0000", oWd);
    end
    clear_model();
  endtask

  task automatic test_one_shot();
    bit ok;
    int bad;
    clear_model();
    gaps = 1'b0;
    fixed_first = 1'b1;
    model_run(0, 'h300, 'h100, 1'b0, 1000);
    start_run(0, 'h300, 'h100, 1'b0);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL one_shot_done got timeout want oDmaDone"); end
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < exp_addr_q.size(); i++)
      if (addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (bad != 0 || addr_q.size() != exp_addr_q.size()) begin
      errors++;
      $display("[TB] FAIL one_shot_adrs got %0d requests (%0d wrong) want %0d", addr_q.size(), bad, exp_addr_q.size());
    end
    checks++;
    if (addr_q.size() > 3 && addr_q[3] !== 32'h2000_0300) begin
      errors++; $display("[TB] FAIL one_shot_last_adrs got %h want 20000300", addr_q[3]);
    end
    bad = 0;
    for (int i = 0; i < we_q.size() && i < exp_data_q.size(); i++)
      if (we_q[i] !== exp_data_q[i]) bad++;
    checks++;
    if (bad != 0 || we_q.size() != exp_addr_q.size() * BL) begin
      errors++;
      $display("[TB] FAIL one_shot_data got %0d words (%0d wrong) want %0d", we_q.size(), bad, exp_addr_q.size() * BL);
    end
    checks++;
`ifdef VIDEO_DMA_BYTE_SWAP_EN
    if (we_q.size() == 0 || we_q[0] !== 16'h3412) begin
      errors++; $display("[TB] FAIL byte_order got %h want 3412", (we_q.size() != 0) ? we_q[0] : 16'hxxxx);
    end
`else
    if (we_q.size() == 0 || we_q[0] !== 16'h1234) begin
      errors++; $display("[TB] FAIL byte_order got %h want 1234", (we_q.size() != 0) ? we_q[0] : 16'hxxxx);
    end
`endif
    checks++;
    if (frame_cnt != exp_frames) begin
      errors++; $display("[TB] FAIL one_shot_frames got %0d want %0d", frame_cnt, exp_frames);
    end
    repeat (5) @(negedge iSCLK);
    #4;
    checks++;
    if (oDmaDone !== 1'b1) begin errors++; $display("[TB] FAIL one_shot_done_held got %b want 1", oDmaDone); end
    @(negedge iSCLK);
    iDmaEnable = 1'b0;
    @(negedge iSCLK);
    #4;
    checks++;
    if (oDmaDone !== 1'b0) begin errors++; $display("[TB] FAIL one_shot_done_clear got %b want 0", oDmaDone); end
  endtask

  task automatic test_alert_throttle();
    bit ok;
    int bad;
    int unsigned s;
    int k;
    clear_model();
    gaps = 1'b1;
    s = $urandom_range(0, 'h3FF00);
    model_run(s, s, 'h100, 1'b0, 10);
    @(negedge iSCLK);
    iRemaingCntAlert = 1'b1;
    iMUfiRdy = 1'b1;
    start_run(s, s, 'h100, 1'b0);
    repeat (50) @(negedge iSCLK);
    checks++;
    if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL alert_hold got %0d requests want 0", addr_q.size()); end
    iRemaingCntAlert = 1'b0;
    iMUfiRdy = 1'b0;
    k = $urandom_range(1, 5);
    repeat (k) @(negedge iSCLK);
    checks++;
    if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL rdy_hold got %0d requests want 0", addr_q.size()); end
    iMUfiRdy = 1'b1;
    #4;
    checks++;
    if (addr_q.size() != 1 || addr_q[0] !== exp_addr_q[0]) begin
      errors++;
      $display("[TB] FAIL alert_release got %0d requests first %h want 1 at %h", addr_q.size(),
               (addr_q.size() != 0) ? addr_q[0] : 32'hxxxxxxxx, exp_addr_q[0]);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL alert_done got timeout want oDmaDone"); end
    bad = 0;
    for (int i = 0; i < we_q.size() && i < exp_data_q.size(); i++)
      if (we_q[i] !== exp_data_q[i]) bad++;
    checks++;
    if (bad != 0 || we_q.size() != BL || frame_cnt != exp_frames) begin
      errors++;
      $display("[TB] FAIL alert_data got %0d words (%0d wrong) %0d frames want %0d words %0d frames",
               we_q.size(), bad, frame_cnt, BL, exp_frames);
    end
    @(negedge iSCLK);
    iDmaEnable = 1'b0;
    @(negedge iSCLK);
  endtask

  task automatic test_cycle_mode();
    bit ok;
    int bad;
    clear_model();
    gaps = 1'b1;
    model_run('h10, 'h110, 'h100, 1'b1, 5);
    start_run('h10, 'h110, 'h100, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge iSCLK);
      if (addr_q.size() >= 5) begin ok = 1'b1; iDmaEnable = 1'b0; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cycle_requests got %0d want 5", addr_q.size()); end
    wait_drain(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cycle_drain got timeout want drained"); end
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < exp_addr_q.size(); i++)
      if (addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (bad != 0 || addr_q.size() != exp_addr_q.size()) begin
      errors++;
      $display("[TB] FAIL cycle_adrs got %0d requests (%0d wrong) want %0d", addr_q.size(), bad, exp_addr_q.size());
    end
    checks++;
    if (frame_cnt != exp_frames) begin
      errors++; $display("[TB] FAIL cycle_frames got %0d want %0d", frame_cnt, exp_frames);
    end
    checks++;
    if (done_seen) begin errors++; $display("[TB] FAIL cycle_dma_done got 1 want 0"); end
    bad = 0;
    for (int i = 0; i < we_q.size() && i < exp_data_q.size(); i++)
      if (we_q[i] !== exp_data_q[i]) bad++;
    checks++;
    if (bad != 0 || we_q.size() != exp_addr_q.size() * BL) begin
      errors++;
      $display("[TB] FAIL cycle_data got %0d words (%0d wrong) want %0d", we_q.size(), bad, exp_addr_q.size() * BL);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int bad;
    int unsigned s;
    clear_model();
    gaps = 1'b0;
    s = $urandom_range(0, 'h3FC00);
    model_run(s, s + 'h300, 'h100, 1'b0, 1);
    start_run(s, s + 'h300, 'h100, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iSCLK);
      if (exp_data_q.size() >= 100) begin ok = 1'b1; iDmaEnable = 1'b0; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL drop_start got %0d words want 100", exp_data_q.size()); end
    wait_drain(600, ok);
    repeat (20) @(negedge iSCLK);
    #4;
    checks++;
    if (addr_q.size() != 1 || addr_q[0] !== exp_addr_q[0]) begin
      errors++;
      $display("[TB] FAIL drop_adrs got %0d requests want 1 at %h", addr_q.size(), exp_addr_q[0]);
    end
    bad = 0;
    for (int i = 0; i < we_q.size() && i < exp_data_q.size(); i++)
      if (we_q[i] !== exp_data_q[i]) bad++;
    checks++;
    if (bad != 0 || we_q.size() != BL) begin
      errors++; $display("[TB] FAIL drop_data got %0d words (%0d wrong) want %0d", we_q.size(), bad, BL);
    end
    checks++;
    if (done_seen || oDmaDone !== 1'b0 || frame_cnt != 0) begin
      errors++; $display("[TB] FAIL drop_status got done %b frames %0d want done 0 frames 0", done_seen, frame_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n_adrs;
    clear_model();
    gaps = 1'b0;
    start_run($urandom_range(0, 'h3FF00), 'h3FFFF, 'h100, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iSCLK);
      if (exp_data_q.size() >= 50) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL mid_reset_start got %0d words want 50", exp_data_q.size()); end
    slave_en = 1'b0;
    iMUfiRvd = 1'b0;
    iSRST = 1'b1;
    iDmaEnable = 1'b0;
    @(negedge iSCLK);
    iSRST = 1'b0;
    #4;
    checks++;
    if ({oMUfiRe, oWe, oFrameDone, oDmaDone, oOverflow} !== 5'b0 || oMUfiAdrs !== 32'h0 || oWd !== 16'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got strobes %b adrs %h wd %h want all 0",
               {oMUfiRe, oWe, oFrameDone, oDmaDone, oOverflow}, oMUfiAdrs, oWd);
    end
    we_q.delete();
    n_adrs = addr_q.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge iSCLK);
      iMUfiRvd = 1'b1;
      iMUfiRd  = 16'($urandom);
    end
    @(negedge iSCLK);
    iMUfiRvd = 1'b0;
    repeat (3) @(negedge iSCLK);
    checks++;
    if (we_q.size() != 0 || addr_q.size() != n_adrs) begin
      errors++;
      $display("[TB] FAIL stray_rvd got %0d writes %0d new requests want 0 0", we_q.size(), addr_q.size() - n_adrs);
    end
    pending = 0;
    slave_en = 1'b1;
  endtask

  task automatic test_overflow();
    bit ok;
    int unsigned s;
    clear_model();
    gaps = 1'b0;
    iFull = 1'b0;
    s = $urandom_range(0, 'h3FF00);
    model_run(s, s, 'h100, 1'b0, 10);
    start_run(s, s, 'h100, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge iSCLK);
      if (we_q.size() >= 20) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || oOverflow !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_before got %b want 0 (%0d words)", oOverflow, we_q.size());
    end
    iFull = 1'b1;
    @(negedge iSCLK);
    iFull = 1'b0;
    @(negedge iSCLK);
    #4;
    checks++;
    if (oOverflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", oOverflow); end
    wait_done(1000, ok);
    #4;
    checks++;
    if (!ok || oOverflow !== 1'b1 || we_q.size() != BL) begin
      errors++;
      $display("[TB] FAIL ovf_sticky got ovf %b %0d words want ovf 1 %0d words", oOverflow, we_q.size(), BL);
    end
    @(negedge iSCLK);
    iDmaEnable = 1'b0;
    iSRST = 1'b1;
    @(negedge iSCLK);
    iSRST = 1'b0;
    #4;
    checks++;
    if (oOverflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_reset got %b want 0", oOverflow); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_one_shot();
    test_alert_throttle();
    test_cycle_mode();
    test_enable_drop();
    test_reset_mid_burst();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
